overdrive_shaper: RTL and testbench



---
 rtl/overdrive_shaper.sv | 183 ++++++++++++++++++
 tb/tb_overdrive_shaper.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/overdrive_shaper.sv
// rtl/overdrive_shaper.sv - four-stage overdrive: ramped pre-gain, then bypass/hard/soft/asymmetric shaping
module overdrive_shaper #(
  parameter int DATA_W    = 24,
  parameter int FRAC_BITS = 12,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 4,
  parameter int N_CH      = 2,
  parameter int RAMP_STEP = 1,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sample,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [1:0]        mode,
  input  logic [GAIN_W-1:0] gain_target,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_sample,
  output logic [CH_W-1:0]   out_ch,
  output logic              clip_flag,
  output logic [GAIN_W-1:0] gain_cur
);
  localparam int PW = 2*DATA_W + GAIN_W;
  localparam int QW = 2*DATA_W;
  localparam logic signed [PW-1:0]     MAX_P    = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MAX_D    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] T_D      = {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_BITS;
  localparam logic signed [DATA_W-1:0] HALF_T_D = T_D >>> 1;
  localparam logic [GAIN_W-1:0]        UNITY    = {{(GAIN_W-1){1'b0}}, 1'b1} << GAIN_FRAC;
  localparam logic [GAIN_W-1:0]        STEP     = GAIN_W'(RAMP_STEP);

  logic [GAIN_W-1:0] gain_cur_q, gain_d, diff;

  logic                     s1_valid_q, s1_sat_q;
  logic signed [DATA_W-1:0] s1_g_q;
  logic [CH_W-1:0]          s1_ch_q;
  logic [1:0]               s1_mode_q;

  logic                     s2_valid_q, s2_sat_q, s2_big_q;
  logic signed [DATA_W-1:0] s2_g_q, s2_x2_q;
  logic [CH_W-1:0]          s2_ch_q;
  logic [1:0]               s2_mode_q;

  logic                     s3_valid_q, s3_clip_q;
  logic signed [DATA_W-1:0] s3_y_q;
  logic [CH_W-1:0]          s3_ch_q;

  logic                     out_valid_q, out_clip_q;
  logic signed [DATA_W-1:0] out_sample_q;
  logic [CH_W-1:0]          out_ch_q;

  logic signed [PW-1:0]     g_ext, gain_ext, prod1, shf1;
  logic signed [DATA_W-1:0] g1_d;
  logic                     sat1;

  logic signed [QW-1:0]     g2_ext;
  logic signed [DATA_W-1:0] x2_d;
  logic                     big2;

  logic signed [QW-1:0]       x2_ext, g3_ext;
  logic signed [DATA_W-1:0]   x3, soft_y, y3_d;
  logic signed [DATA_W+1:0]   g_e2, x3_e2, s3w;
  logic                       clip3_d;

  always_comb begin
    gain_d = gain_cur_q;
    diff   = '0;
    if (gain_target > gain_cur_q) begin
      diff   = gain_target - gain_cur_q;
      gain_d = gain_cur_q + ((diff > STEP) ? STEP : diff);
    end else if (gain_target < gain_cur_q) begin
      diff   = gain_cur_q - gain_target;
      gain_d = gain_cur_q - ((diff > STEP) ? STEP : diff);
    end
  end

  always_comb begin
    g_ext    = {{(PW-DATA_W){in_sample[DATA_W-1]}}, in_sample};
    gain_ext = {{(PW-GAIN_W){1'b0}}, gain_cur_q};
    prod1    = g_ext * gain_ext;
    shf1     = prod1 >>> GAIN_FRAC;
    sat1     = 1'b0;
    g1_d     = shf1[DATA_W-1:0];
    if (shf1 > MAX_P) begin
      g1_d = MAX_D;
      sat1 = 1'b1;
    end else if (shf1 < -MAX_P) begin
      g1_d = -MAX_D;
      sat1 = 1'b1;
    end
  end

  // Square is only consumed below threshold, so it is zeroed above it to stay in range.
  always_comb begin
    g2_ext = {{(QW-DATA_W){s1_g_q[DATA_W-1]}}, s1_g_q};
    big2   = (s1_g_q >= T_D) || (s1_g_q <= -T_D);
    x2_d   = big2 ? '0 : DATA_W'((g2_ext * g2_ext) >>> FRAC_BITS);
  end

  always_comb begin
    x2_ext = {{(QW-DATA_W){s2_x2_q[DATA_W-1]}}, s2_x2_q};
    g3_ext = {{(QW-DATA_W){s2_g_q[DATA_W-1]}}, s2_g_q};
    x3     = DATA_W'((x2_ext * g3_ext) >>> FRAC_BITS);
    g_e2   = {{2{s2_g_q[DATA_W-1]}}, s2_g_q};
    x3_e2  = {{2{x3[DATA_W-1]}}, x3};
    s3w    = g_e2 + (g_e2 <<< 1) - x3_e2;
    soft_y = s2_big_q ? (s2_g_q[DATA_W-1] ? -T_D : T_D) : DATA_W'(s3w >>> 1);
    y3_d    = s2_g_q;
    clip3_d = s2_sat_q;
    case (s2_mode_q)
      2'd1: begin
        if (s2_g_q > T_D) begin
          y3_d = T_D;   clip3_d = 1'b1;
        end else if (s2_g_q < -T_D) begin
          y3_d = -T_D;  clip3_d = 1'b1;
        end
      end
      2'd2: begin
        y3_d    = soft_y;
        clip3_d = s2_sat_q | s2_big_q;
      end
      2'd3: begin
        if (!s2_g_q[DATA_W-1]) begin
          y3_d    = soft_y;
          clip3_d = s2_sat_q | s2_big_q;
        end else if (s2_g_q < -HALF_T_D) begin
          y3_d = -HALF_T_D;  clip3_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gain_cur_q   <= UNITY;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s3_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      out_ch_q     <= '0;
      out_clip_q   <= 1'b0;
    end else begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      s3_valid_q  <= s2_valid_q;
      out_valid_q <= s3_valid_q;
      if (in_valid) begin
        gain_cur_q <= gain_d;
        s1_g_q     <= g1_d;
        s1_sat_q   <= sat1;
        s1_ch_q    <= in_ch;
        s1_mode_q  <= mode;
      end
      if (s1_valid_q) begin
        s2_g_q    <= s1_g_q;
        s2_x2_q   <= x2_d;
        s2_big_q  <= big2;
        s2_sat_q  <= s1_sat_q;
        s2_ch_q   <= s1_ch_q;
        s2_mode_q <= s1_mode_q;
      end
      if (s2_valid_q) begin
        s3_y_q    <= y3_d;
        s3_clip_q <= clip3_d;
        s3_ch_q   <= s2_ch_q;
      end
      if (s3_valid_q) begin
        out_sample_q <= s3_y_q;
        out_ch_q     <= s3_ch_q;
        out_clip_q   <= s3_clip_q;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign out_ch     = out_ch_q;
  assign clip_flag  = out_clip_q;
  assign gain_cur   = gain_cur_q;
endmodule

// File: tb/tb_overdrive_shaper.sv
// tb/tb_overdrive_shaper.sv - directed scoreboard bench for overdrive_shaper
module tb_overdrive_shaper;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [23:0] in_sample;
  logic [0:0]  in_ch;
  logic [1:0]  mode;
  logic [7:0]  gain_target;
  logic        out_valid;
  logic [23:0] out_sample;
  logic [0:0]  out_ch;
  logic        clip_flag;
  logic [7:0]  gain_cur;

  overdrive_shaper dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample), .in_ch(in_ch),
    .mode(mode), .gain_target(gain_target), .out_valid(out_valid), .out_sample(out_sample),
    .out_ch(out_ch), .clip_flag(clip_flag), .gain_cur(gain_cur)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y;
    bit c;
    int ch;
    int stamp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nout = 0;
  int gm = 16;
  int tgt = 16;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check($sformatf("out%0d_sample", nout), $signed(out_sample), e.y);
        check($sformatf("out%0d_clip", nout), clip_flag, e.c);
        check($sformatf("out%0d_ch", nout), out_ch, e.ch);
        check($sformatf("out%0d_latency", nout), cyc - e.stamp, 4);
        nout++;
      end
    end
  end

  function automatic void model(input int s, input int gn, input int m, output int y, output bit c);
    longint g, x2, x3, t, sy;
    bit big;
    t = 4096;
    g = (longint'(s) * gn) >>> 4;
    c = 1'b0;
    if (g > 8388607) begin g = 8388607; c = 1'b1; end
    else if (g < -8388607) begin g = -8388607; c = 1'b1; end
    big = (g >= t) || (g <= -t);
    x2 = (g * g) >>> 12;
    x3 = (x2 * g) >>> 12;
    sy = big ? ((g < 0) ? -t : t) : ((3 * g - x3) >>> 1);
    y = int'(g);
    case (m)
      1: if (g > t) begin y = int'(t); c = 1'b1; end
         else if (g < -t) begin y = int'(-t); c = 1'b1; end
      2: begin y = int'(sy); c = c | big; end
      3: if (g >= 0) begin y = int'(sy); c = c | big; end
         else if (g < -2048) begin y = -2048; c = 1'b1; end
      default: ;
    endcase
  endfunction

  task automatic send(input int s, input int ch, input int m, input int ey, input bit ec);
    @(negedge clk);
    in_valid = 1'b1;
    in_sample = s[23:0];
    in_ch = ch[0:0];
    mode = m[1:0];
    sb.push_back('{y: ey, c: ec, ch: ch, stamp: cyc});
    if (tgt > gm) gm++;
    else if (tgt < gm) gm--;
  endtask

  task automatic send_m(input int s, input int ch, input int m);
    int y;
    bit c;
    model(s, gm, m, y, c);
    send(s, ch, m, y, c);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic set_target(input int v);
    tgt = v;
    gain_target = v[7:0];
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[8] = '{1000, -1500, 3000, -4000, 4500, -5000, 2500, -200};
    int spurious;
    rst = 1'b1; in_valid = 1'b0; in_sample = '0; in_ch = '0; mode = 2'd0; gain_target = 8'd16;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sample", $signed(out_sample), 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_clip", clip_flag, 0);
    check("rst_gain_cur", gain_cur, 16);

    send(2048, 0, 2, 2816, 0);
    send(-2048, 1, 2, -2816, 0);
    send(4096, 0, 2, 4096, 1);
    send(0, 1, 2, 0, 0);
    send(5000, 0, 1, 4096, 1);
    send(-3000, 1, 1, -3000, 0);
    send(-3000, 0, 3, -2048, 1);
    send(2048, 0, 3, 2816, 0);
    idle(1);
    drain();
    idle(3);
    check("hold_out_valid", out_valid, 0);
    check("hold_out_sample", $signed(out_sample), 2816);

    set_target(32);
    for (int k = 0; k < 20; k++)
      send(1000, 0, 0, (1000 * (16 + ((k < 16) ? k : 16))) >>> 4, 0);
    idle(1);
    drain();
    check("ramp_gain_final", gain_cur, 32);
    set_target(40);
    idle(5);
    check("ramp_stall_no_valid", gain_cur, 32);
    set_target(32);

    send(4194304, 0, 0, 8388607, 1);
    send(-4194304, 1, 0, -8388607, 1);
    idle(1);
    drain();

    set_target(16);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        idle(1);
        set_target(24);
      end
      send_m(vals[i], i % 2, (i % 2 == 0) ? 1 : 2);
      if (i % 3 == 2) idle(1 + $urandom_range(0, 2));
    end
    idle(1);
    drain();
    check("redirect_gain", gain_cur, gm);

    set_target(40);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sample = 24'd3000; in_ch = 1'b1; mode = 2'd0;
    end
    @(negedge clk);
    rst = 1'b1;
    in_sample = 24'd500;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    gm = 16;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_sample", $signed(out_sample), 0);
    check("midrst_out_ch", out_ch, 0);
    check("midrst_clip", clip_flag, 0);
    check("midrst_gain_cur", gain_cur, 16);
    spurious = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    check("midrst_no_out_valid", spurious, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
